lambda_loader: RTL and testbench

LAMBDA_LOADER -- requirements
Module: lambda_loader

---
 rtl/lambda_loader.sv | 87 ++++++++
 tb/tb_lambda_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lambda_loader.sv
// rtl/lambda_loader.sv - streams one frame of channel LLRs into the lambda SRAM with symmetric saturation
module lambda_loader #(
  parameter int WIDTH      = 8,
  parameter int IN_WIDTH   = 12,
  parameter int ROW_NUMBER = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic                       i_valid,
  input  logic signed [IN_WIDTH-1:0] i_data,
  output logic                       o_ready,
  output logic                       o_wen,
  output logic [19:0]                o_waddr,
  output logic [WIDTH-1:0]           o_wdata,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [15:0]                o_sat_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] LAST = 2'd2;

  localparam logic [19:0] LAST_ADDR = 20'(ROW_NUMBER - 1);
  // Clip range is symmetric so the most-negative code never reaches the SRAM.
  localparam logic signed [IN_WIDTH-1:0] POS_MAX = IN_WIDTH'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [IN_WIDTH-1:0] NEG_MAX = -POS_MAX;

  logic [1:0]       state;
  logic [19:0]      addr_cnt;
  logic             accept;
  logic             clipped;
  logic [WIDTH-1:0] sat_data;

  assign o_ready = (state == LOAD);
  assign o_busy  = (state != IDLE);
  assign o_done  = (state == LAST);
  assign accept  = i_valid && (state == LOAD);

  always_comb begin
    clipped  = 1'b0;
    sat_data = i_data[WIDTH-1:0];
    if (i_data > POS_MAX) begin
      clipped  = 1'b1;
      sat_data = POS_MAX[WIDTH-1:0];
    end else if (i_data < NEG_MAX) begin
      clipped  = 1'b1;
      sat_data = NEG_MAX[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_cnt  <= 20'd0;
      o_wen     <= 1'b0;
      o_waddr   <= 20'd0;
      o_wdata   <= '0;
      o_sat_cnt <= 16'd0;
    end else begin
      o_wen <= accept;
      if (accept) begin
        o_waddr  <= addr_cnt;
        o_wdata  <= sat_data;
        addr_cnt <= addr_cnt + 20'd1;
        if (clipped && (o_sat_cnt != 16'hFFFF))
          o_sat_cnt <= o_sat_cnt + 16'd1;
      end
      case (state)
        IDLE: begin
          if (i_start) begin
            state     <= LOAD;
            addr_cnt  <= 20'd0;
            o_sat_cnt <= 16'd0;
          end
        end
        LOAD: begin
          if (accept && (addr_cnt == LAST_ADDR))
            state <= LAST;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lambda_loader.sv
// tb/tb_lambda_loader.sv - directed self-checking bench for lambda_loader
module tb_lambda_loader;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_start;
  logic               i_valid;
  logic signed [11:0] i_data;
  logic               o_ready;
  logic               o_wen;
  logic [19:0]        o_waddr;
  logic [7:0]         o_wdata;
  logic               o_busy;
  logic               o_done;
  logic [15:0]        o_sat_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lambda_loader #(.WIDTH(8), .IN_WIDTH(12), .ROW_NUMBER(4)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_wen(o_wen), .o_waddr(o_waddr), .o_wdata(o_wdata),
    .o_busy(o_busy), .o_done(o_done), .o_sat_cnt(o_sat_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_data = '0;
    step();
    step();
    n_cmp++;
    if ({o_ready, o_wen, o_busy, o_done} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: got %b want 0000", {o_ready, o_wen, o_busy, o_done});
    end
    n_cmp++;
    if (o_waddr !== 20'd0 || o_wdata !== 8'h00 || o_sat_cnt !== 16'd0) begin
      n_err++; $display("FAIL reset_regs: addr=%0d data=%h sat=%0d want 0/00/0", o_waddr, o_wdata, o_sat_cnt);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int          d[4] = '{5, -3, 0, 127};
    logic [7:0]  e[4] = '{8'h05, 8'hFD, 8'h00, 8'h7F};
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    n_cmp++;
    if (o_ready !== 1'b1 || o_busy !== 1'b1 || o_wen !== 1'b0) begin
      n_err++; $display("FAIL basic_load_entry: ready=%b busy=%b wen=%b want 1 1 0", o_ready, o_busy, o_wen);
    end
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1; i_data = 12'(d[i]);
      step();
      n_cmp++;
      if (o_wen !== 1'b1 || o_waddr !== 20'(i) || o_wdata !== e[i]) begin
        n_err++; $display("FAIL basic_write[%0d]: wen=%b addr=%0d data=%h want 1 %0d %h", i, o_wen, o_waddr, o_wdata, i, e[i]);
      end
      n_cmp++;
      if (o_done !== (i == 3)) begin
        n_err++; $display("FAIL basic_done[%0d]: got %b want %b", i, o_done, (i == 3));
      end
    end
    n_cmp++;
    if (o_ready !== 1'b0 || o_busy !== 1'b1) begin
      n_err++; $display("FAIL basic_last_state: ready=%b busy=%b want 0 1", o_ready, o_busy);
    end
    i_valid = 1'b0;
    step();
    n_cmp++;
    if (o_wen !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b0 || o_sat_cnt !== 16'd0 || o_waddr !== 20'd3) begin
      n_err++; $display("FAIL basic_idle: wen=%b done=%b busy=%b sat=%0d addr=%0d want 0 0 0 0 3", o_wen, o_done, o_busy, o_sat_cnt, o_waddr);
    end
  endtask

  task automatic test_saturation();
    int          d[4] = '{200, -200, -127, -128};
    logic [7:0]  e[4] = '{8'h7F, 8'h81, 8'h81, 8'h81};
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1; i_data = 12'(d[i]);
      step();
      n_cmp++;
      if (o_wen !== 1'b1 || o_waddr !== 20'(i) || o_wdata !== e[i]) begin
        n_err++; $display("FAIL sat_write[%0d]: wen=%b addr=%0d data=%h want 1 %0d %h", i, o_wen, o_waddr, o_wdata, i, e[i]);
      end
    end
    i_valid = 1'b0;
    step();
    step();
    n_cmp++;
    if (o_sat_cnt !== 16'd3) begin
      n_err++; $display("FAIL sat_count_held: got %0d want 3", o_sat_cnt);
    end
  endtask

  task automatic test_gaps();
    logic        v[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0]  e[4] = '{8'h0A, 8'h14, 8'h1E, 8'h28};
    int k = 0;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    n_cmp++;
    if (o_sat_cnt !== 16'd0) begin
      n_err++; $display("FAIL gap_sat_clear: got %0d want 0", o_sat_cnt);
    end
    for (int i = 0; i < 7; i++) begin
      i_valid = v[i];
      i_data  = v[i] ? 12'((k + 1) * 10) : 12'd99;
      step();
      n_cmp++;
      if (v[i]) begin
        if (o_wen !== 1'b1 || o_waddr !== 20'(k) || o_wdata !== e[k]) begin
          n_err++; $display("FAIL gap_write[%0d]: wen=%b addr=%0d data=%h want 1 %0d %h", i, o_wen, o_waddr, o_wdata, k, e[k]);
        end
        k++;
      end else if (o_wen !== 1'b0 || o_waddr !== 20'(k - 1)) begin
        n_err++; $display("FAIL gap_idle[%0d]: wen=%b addr=%0d want 0 %0d", i, o_wen, o_waddr, k - 1);
      end
    end
    n_cmp++;
    if (o_done !== 1'b1) begin
      n_err++; $display("FAIL gap_done: got %b want 1", o_done);
    end
    i_valid = 1'b0;
    step();
  endtask

  task automatic test_idle_ignore();
    i_start = 1'b1; i_valid = 1'b1; i_data = 12'd33;
    step();
    n_cmp++;
    if (o_wen !== 1'b0 || o_ready !== 1'b1) begin
      n_err++; $display("FAIL idle_valid_ignored: wen=%b ready=%b want 0 1", o_wen, o_ready);
    end
    i_start = 1'b0; i_valid = 1'b0;
    step();
    n_cmp++;
    if (o_wen !== 1'b0) begin
      n_err++; $display("FAIL idle_no_write: wen=%b want 0", o_wen);
    end
    for (int i = 0; i < 4; i++) begin
      i_start = (i == 2);
      i_valid = 1'b1; i_data = 12'(i + 1);
      step();
      n_cmp++;
      if (o_wen !== 1'b1 || o_waddr !== 20'(i) || o_wdata !== 8'(i + 1)) begin
        n_err++; $display("FAIL load_start_ignored[%0d]: wen=%b addr=%0d data=%h want 1 %0d %h", i, o_wen, o_waddr, o_wdata, i, 8'(i + 1));
      end
    end
    i_start = 1'b0; i_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      i_valid = 1'b1; i_data = 12'd200;
      step();
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({o_ready, o_wen, o_busy, o_done} !== 4'b0000 || o_waddr !== 20'd0 || o_wdata !== 8'h00 || o_sat_cnt !== 16'd0) begin
      n_err++; $display("FAIL async_reset: flags=%b addr=%0d data=%h sat=%0d want all 0", {o_ready, o_wen, o_busy, o_done}, o_waddr, o_wdata, o_sat_cnt);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (o_wen !== 1'b0 || o_busy !== 1'b0) begin
        n_err++; $display("FAIL post_reset_quiet[%0d]: wen=%b busy=%b want 0 0", i, o_wen, o_busy);
      end
    end
    i_valid = 1'b0; i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1; i_data = 12'(-i);
      step();
      n_cmp++;
      if (o_wen !== 1'b1 || o_waddr !== 20'(i) || o_wdata !== 8'(-i)) begin
        n_err++; $display("FAIL reload_write[%0d]: wen=%b addr=%0d data=%h want 1 %0d %h", i, o_wen, o_waddr, o_wdata, i, 8'(-i));
      end
    end
    i_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int          d1[4] = '{300, 1, 2, 3};
    int          d2[4] = '{-1, -300, 4, -5};
    logic [7:0]  e1[4] = '{8'h7F, 8'h01, 8'h02, 8'h03};
    logic [7:0]  e2[4] = '{8'hFF, 8'h81, 8'h04, 8'hFB};
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1; i_data = 12'(d1[i]);
      step();
      n_cmp++;
      if (o_wen !== 1'b1 || o_waddr !== 20'(i) || o_wdata !== e1[i]) begin
        n_err++; $display("FAIL b2b_frame1[%0d]: wen=%b addr=%0d data=%h want 1 %0d %h", i, o_wen, o_waddr, o_wdata, i, e1[i]);
      end
    end
    n_cmp++;
    if (o_done !== 1'b1 || o_sat_cnt !== 16'd1) begin
      n_err++; $display("FAIL b2b_frame1_done: done=%b sat=%0d want 1 1", o_done, o_sat_cnt);
    end
    i_valid = 1'b0; i_start = 1'b1;
    step();
    n_cmp++;
    if (o_busy !== 1'b0 || o_sat_cnt !== 16'd1) begin
      n_err++; $display("FAIL start_in_last_ignored: busy=%b sat=%0d want 0 1", o_busy, o_sat_cnt);
    end
    step();
    i_start = 1'b0;
    n_cmp++;
    if (o_ready !== 1'b1 || o_sat_cnt !== 16'd0) begin
      n_err++; $display("FAIL b2b_second_start: ready=%b sat=%0d want 1 0", o_ready, o_sat_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1; i_data = 12'(d2[i]);
      step();
      n_cmp++;
      if (o_wen !== 1'b1 || o_waddr !== 20'(i) || o_wdata !== e2[i]) begin
        n_err++; $display("FAIL b2b_frame2[%0d]: wen=%b addr=%0d data=%h want 1 %0d %h", i, o_wen, o_waddr, o_wdata, i, e2[i]);
      end
    end
    i_valid = 1'b0;
    step();
    n_cmp++;
    if (o_sat_cnt !== 16'd1 || o_busy !== 1'b0) begin
      n_err++; $display("FAIL b2b_frame2_end: sat=%0d busy=%b want 1 0", o_sat_cnt, o_busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_gaps();
    test_idle_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
